// File: rtl/sipo_rx.sv
// sipo_rx: LSB-first serial-to-parallel receiver with a valid/ready
// output register and sticky overrun / frame-error flags.
module sipo_rx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             frame_start,
  input  logic             out_ready,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nx;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nx;
  logic             done;
  logic             restart;
  logic             accept;
  logic             room;

  assign accept = out_valid & out_ready;
  assign room   = ~out_valid | out_ready;
  assign busy   = (state == SHIFT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      sreg  <= sreg_nx;
      cnt   <= cnt_nx;
    end
  end

  // Samples enter at the MSB so sample n lands in bit n after WIDTH shifts.
  always_comb begin
    state_nx = state;
    sreg_nx  = sreg;
    cnt_nx   = cnt;
    done     = 1'b0;
    restart  = 1'b0;
    unique case (state)
      IDLE: begin
        if (frame_start) begin
          sreg_nx  = {serial_in, sreg[WIDTH-1:1]};
          cnt_nx   = CW'(1);
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        sreg_nx = {serial_in, sreg[WIDTH-1:1]};
        if (frame_start) begin
          restart = 1'b1;
          cnt_nx  = CW'(1);
        end else if (cnt == LAST) begin
          done     = 1'b1;
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parallel_out <= '0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      if (done && room) begin
        parallel_out <= sreg_nx;
        out_valid    <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
      // A new event on the clearing edge keeps the flag set.
      overrun   <= (done & ~room) | (overrun & ~clr_flags);
      frame_err <= restart | (frame_err & ~clr_flags);
    end
  end

endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-to-parallel receive stage that sits directly downstream of the team's parallel-in/serial-out shifter. It samples an LSB-first serial stream under a frame-start strobe, rebuilds the WIDTH-bit word, and presents it on a valid/ready output register. Sticky flags report words dropped because the consumer stalled, and frames cut short by a new start. It recovers the exact word loaded into the upstream shifter, so the pair forms a complete serial link.

## Interface
- WIDTH, 4: word length in bits; legal range WIDTH >= 2.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- serial_in  in  1  serial data; LSB first; one bit per clock.
- frame_start  in  1  high on the edge that samples bit 0 of a frame.
- out_ready  in  1  consumer accepts the output word.
- clr_flags  in  1  synchronous clear of overrun and frame_err.
- parallel_out  out  WIDTH  last completed word; bit i = i-th sampled bit.
- out_valid  out  1  parallel_out holds an unconsumed word.
- busy  out  1  a frame is in progress (SHIFT state).
- overrun  out  1  sticky: a completed word was dropped.
- frame_err  out  1  sticky: a frame was restarted before completion.

## Operation
- Reset (async, active-high) forces IDLE and clears all state: shift register 0, bit counter 0, parallel_out 0, out_valid 0, busy 0, overrun 0, frame_err 0.
- States:
  - IDLE: serial_in is ignored.
  - SHIFT: bits are being collected.
- Frame timing: frame_start is sampled at an edge together with serial_in, which carries bit 0. Bits 1..WIDTH-1 are sampled on the following WIDTH-1 edges.
- Bit placement: the sample with index n is written to shift-register bit n. The shift register fills by right-shifting in at the MSB, so upstream word 1010 (sent as 0,1,0,1) reconstructs as 1010.
- IDLE with frame_start=1: capture bit 0, set counter to 1, go to SHIFT.
- SHIFT, counter < WIDTH-1, frame_start=0: capture the bit and increment the counter.
- SHIFT, counter == WIDTH-1, frame_start=0: capture the last bit, then complete the word and return to IDLE.
- Completing a word:
  - If the output register is free, or is being consumed on the same edge (out_valid & out_ready), load the word into parallel_out and set out_valid=1.
  - Otherwise drop the new word, keep the old one, and set overrun=1.
- frame_start=1 while in SHIFT: abandon the partial word, set frame_err=1, and treat this edge as bit 0 of a new frame (counter=1, stay in SHIFT).
- Output handshake: at an edge with out_valid & out_ready, out_valid clears unless a word completes on that same edge. parallel_out holds its value after being consumed.
- clr_flags=1 clears overrun and frame_err at the edge. If a new overrun or frame_err event occurs on that same edge, the flag sets (set wins).
- busy = (state == SHIFT).

## Timing
- Start of frame: frame_start sampled at edge k gives busy=1 after edge k.
- Last bit: sampled at edge k+WIDTH-1, after which out_valid=1, parallel_out is valid, and busy=0.
- Latency: WIDTH-1 cycles from the start edge to out_valid.
- Back-to-back frames: a new frame_start is legal at edge k+WIDTH, giving zero idle cycles between frames.
- Upstream alignment: the upstream load edge L puts bit 0 on the serial line after L. frame_start is therefore asserted for the cycle after L and sampled at edge L+1.
- Output stability: out_valid and parallel_out are registered with no combinational path from the inputs. parallel_out is stable while out_valid=1 and out_ready=0.
- Mid-frame reset: aborts the frame immediately; no word is emitted and no flag is set.

## Test plan
- Basic frame, WIDTH=4: frame_start with serial sequence 0,1,0,1 and out_ready=1 -> out_valid=1 and parallel_out=1010 after the 4th edge; busy is high for 3 cycles; out_valid clears one edge later.
- Back-to-back frames: 1010 then 1110 (serial 0,1,1,1) with the second frame_start at edge k+4 -> two words 1010 and 1110 in order; overrun=0.
- Consumer stall: out_ready=0 through two full frames, 1010 then 0110 -> parallel_out stays 1010 and overrun=1. Then out_ready=1 -> 1010 is consumed, out_valid=0. clr_flags -> overrun=0.
- Same-edge completion and accept: the second word completes on the edge where the first word is accepted -> no overrun, out_valid stays 1, parallel_out switches to the second word.
- Restart mid-frame: frame_start, two bits, frame_start again, then four bits 1,1,0,0 -> frame_err=1 and exactly one word emitted, parallel_out=0011.
- Async reset: reset asserted after 2 bits of a frame -> all outputs 0 immediately. After release a full frame 1001 -> parallel_out=1001 with flags 0.
